// File: rtl/system_memory_v3.sv
// Grid-state register for the Conway engine: serial load, generation
// capture, rotating readout, with frame, generation and still-life tracking.
module system_memory_v3 #(
    parameter int WIDTH     = 8,
    parameter int HEIGHT    = 8,
    parameter int GEN_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH*HEIGHT-1:0]   grid_in,
    input  logic                      serial_in,
    input  logic                      load_mode,
    input  logic                      run_mode,
    input  logic                      unload_mode,
    output logic [WIDTH*HEIGHT-1:0]   data_out,
    output logic                      serial_out,
    output logic                      frame_done,
    output logic [GEN_WIDTH-1:0]      generation,
    output logic                      stable
);

    localparam int CELLS = WIDTH * HEIGHT;
    localparam int CNT_W = $clog2(CELLS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CELLS - 1);

    typedef enum logic [1:0] {
        HOLD,
        LOAD,
        UNLOAD,
        RUN
    } mode_t;

    mode_t            mode;
    mode_t            prev_mode;
    logic [CNT_W-1:0] bit_count;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_next;
    logic [CELLS-1:0] data_next;
    logic [GEN_WIDTH-1:0] gen_next;
    logic             stable_next;
    logic             fd_next;
    logic             shift_bit;

    assign serial_out = data_out[CELLS-1];

    always_comb begin
        mode = HOLD;
        priority case (1'b1)
            run_mode:    mode = RUN;
            unload_mode: mode = UNLOAD;
            load_mode:   mode = LOAD;
            default:     mode = HOLD;
        endcase
    end

    // A change into a shifting mode starts a fresh frame at position 0.
    assign cnt_base  = (mode != prev_mode) ? '0 : bit_count;
    assign shift_bit = (mode == LOAD) ? serial_in : data_out[CELLS-1];

    always_comb begin
        data_next   = data_out;
        cnt_next    = bit_count;
        gen_next    = generation;
        stable_next = stable;
        fd_next     = 1'b0;
        case (mode)
            RUN: begin
                data_next   = grid_in;
                gen_next    = generation + GEN_WIDTH'(1);
                stable_next = (grid_in == data_out);
                cnt_next    = '0;
            end
            LOAD, UNLOAD: begin
                data_next = {data_out[CELLS-2:0], shift_bit};
                if (cnt_base == LAST) begin
                    cnt_next = '0;
                    fd_next  = 1'b1;
                end else begin
                    cnt_next = cnt_base + CNT_W'(1);
                end
                if (mode == LOAD) begin
                    stable_next = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out   <= '0;
            bit_count  <= '0;
            prev_mode  <= HOLD;
            frame_done <= 1'b0;
            generation <= '0;
            stable     <= 1'b0;
        end else begin
            data_out   <= data_next;
            bit_count  <= cnt_next;
            prev_mode  <= mode;
            frame_done <= fd_next;
            generation <= gen_next;
            stable     <= stable_next;
        end
    end

endmodule

// File: tb/tb_system_memory_v3.sv
// Randomised and directed bench for system_memory_v3 (3x2 grid, 4-bit
// generation) against a run-length based reference model.
module tb_system_memory_v3;

    localparam int W = 3;
    localparam int H = 2;
    localparam int GW = 4;
    localparam int CELLS = W * H;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [CELLS-1:0] grid_in = '0;
    logic             serial_in = 1'b0;
    logic             load_mode = 1'b0;
    logic             run_mode = 1'b0;
    logic             unload_mode = 1'b0;
    logic [CELLS-1:0] data_out;
    logic             serial_out;
    logic             frame_done;
    logic [GW-1:0]    generation;
    logic             stable;

    system_memory_v3 #(.WIDTH(W), .HEIGHT(H), .GEN_WIDTH(GW)) dut (
        .clk(clk),
        .reset(reset),
        .grid_in(grid_in),
        .serial_in(serial_in),
        .load_mode(load_mode),
        .run_mode(run_mode),
        .unload_mode(unload_mode),
        .data_out(data_out),
        .serial_out(serial_out),
        .frame_done(frame_done),
        .generation(generation),
        .stable(stable)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // reference model state
    logic [CELLS-1:0] m_grid;
    int               m_gen;
    logic             m_stable;
    logic             m_fd;
    int               m_prev;
    int               m_run;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_grid = '0;
        m_gen = 0;
        m_stable = 1'b0;
        m_fd = 1'b0;
        m_prev = 0;
        m_run = 0;
    endtask

    // mode: 0 hold, 1 load, 2 unload, 3 run
    task automatic model_edge(input logic r, input logic u, input logic l,
                              input logic s, input logic [CELLS-1:0] g);
        int mode;
        mode = r ? 3 : (u ? 2 : (l ? 1 : 0));
        if (mode == 3) begin
            m_stable = (g == m_grid);
            m_grid = g;
            m_gen = (m_gen + 1) % (1 << GW);
            m_fd = 1'b0;
            m_run = 0;
        end else if (mode == 0) begin
            m_fd = 1'b0;
            m_run = 0;
        end else begin
            if (mode != m_prev) m_run = 0;
            m_run++;
            m_fd = (m_run % CELLS) == 0;
            if (mode == 1) begin
                m_grid = (m_grid << 1) | CELLS'(s);
                m_stable = 1'b0;
            end else begin
                m_grid = (m_grid << 1) | CELLS'(m_grid >> (CELLS - 1));
            end
        end
        m_prev = mode;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".data"}, 32'(data_out), 32'(m_grid));
        chk({tag, ".fd"}, 32'(frame_done), 32'(m_fd));
        chk({tag, ".gen"}, 32'(generation), 32'(m_gen));
        chk({tag, ".stable"}, 32'(stable), 32'(m_stable));
        chk({tag, ".sout"}, 32'(serial_out), 32'(m_grid[CELLS-1]));
    endtask

    task automatic step(input logic r, input logic u, input logic l,
                        input logic s, input logic [CELLS-1:0] g);
        run_mode = r;
        unload_mode = u;
        load_mode = l;
        serial_in = s;
        grid_in = g;
        @(posedge clk);
        #1;
        model_edge(r, u, l, s, g);
        check_all("step");
    endtask

    task automatic async_reset(input int cycles);
        run_mode = 1'b0;
        unload_mode = 1'b0;
        load_mode = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("arst");
        repeat (cycles) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_all("rel");
    endtask

    logic [CELLS-1:0] pat;
    int pulses;

    initial begin
        model_reset();
        // 1: reset with all-ones inputs and no mode
        grid_in = '1;
        serial_in = 1'b1;
        async_reset(5);
        chk("rst.data", 32'(data_out), 32'h0);
        chk("rst.gen", 32'(generation), 32'h0);

        // 2: load 1,0,1,1,0,1
        pat = 6'b101101;
        for (int i = CELLS - 1; i >= 0; i--) begin
            step(0, 0, 1, pat[i], '1);
            if (i != 0) chk("load.fd_early", 32'(frame_done), 32'h0);
        end
        chk("load.data", 32'(data_out), 32'h2d);
        chk("load.fd", 32'(frame_done), 32'h1);
        step(0, 0, 1, 1'b1, '1);
        chk("load7.fd", 32'(frame_done), 32'h0);

        // 3: reload then unload MSB-first
        async_reset(1);
        for (int i = CELLS - 1; i >= 0; i--) step(0, 0, 1, pat[i], '0);
        for (int i = CELLS - 1; i >= 0; i--) begin
            run_mode = 1'b0;
            unload_mode = 1'b1;
            #1;
            chk("unload.sout", 32'(serial_out), 32'(pat[i]));
            step(0, 1, 0, 1'b0, '0);
        end
        chk("unload.data", 32'(data_out), 32'h2d);
        chk("unload.fd", 32'(frame_done), 32'h1);

        // 4: run outranks load, stable detection
        step(1, 0, 1, 1'b1, 6'b000110);
        chk("run1.data", 32'(data_out), 32'h06);
        chk("run1.gen", 32'(generation), 32'h1);
        chk("run1.stable", 32'(stable), 32'h0);
        step(1, 0, 1, 1'b1, 6'b000110);
        chk("run2.gen", 32'(generation), 32'h2);
        chk("run2.stable", 32'(stable), 32'h1);
        step(1, 0, 0, 1'b0, 6'b000111);
        chk("run3.stable", 32'(stable), 32'h0);

        // 5: 16 runs wrap the 4-bit counter back to 3
        repeat (16) step(1, 0, 0, 1'b0, 6'b000111);
        chk("wrap.gen", 32'(generation), 32'h3);
        chk("wrap.stable", 32'(stable), 32'h1);

        // 6: hold restarts the frame count
        pulses = 0;
        repeat (3) begin
            step(0, 0, 1, 1'b1, '0);
            pulses += int'(frame_done);
        end
        step(0, 0, 0, 1'b0, '0);
        pulses += int'(frame_done);
        for (int i = 0; i < CELLS; i++) begin
            step(0, 0, 1, 1'b1, '0);
            if (i < CELLS - 1) pulses += int'(frame_done);
        end
        chk("restart.nopulse", 32'(pulses), 32'h0);
        chk("restart.fd", 32'(frame_done), 32'h1);

        // mid-frame async reset
        step(0, 0, 1, 1'b1, '0);
        step(0, 0, 1, 1'b1, '0);
        async_reset(2);
        chk("midrst.data", 32'(data_out), 32'h0);
        chk("midrst.gen", 32'(generation), 32'h0);

        // random phase
        for (int i = 0; i < 600; i++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 2) async_reset(int'($urandom_range(1, 3)));
            else if (sel < 10) step(1, 1'($urandom), 1'($urandom),
                                   1'($urandom),
                                   CELLS'($urandom_range(0, 3) == 0 ?
                                          m_grid : CELLS'($urandom)));
            else if (sel < 20) step(0, 0, 0, 1'($urandom), CELLS'($urandom));
            else if (sel < 55) step(0, 1, 1'($urandom), 1'($urandom),
                                    CELLS'($urandom));
            else step(0, 0, 1, 1'($urandom), CELLS'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
